gshare_branch_predictor: RTL

Gshare direction predictor with a direct-mapped branch target buffer that sits in front of the fetch stage. It supplies `branch_guess`, the 5-bit `branch_history` snapshot and the predicted target that fetch latches into the fetch→decode pipeline block. It is trained non-speculatively by the execute stage when a conditional branch resolves.

---
 rtl/gshare_branch_predictor.sv | 88 ++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB in front of fetch.
// Predictions are combinational; training arrives from execute and is non-speculative.
module gshare_branch_predictor #(
  parameter int HIST_W  = 5,
  parameter int BTB_IDX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_fetch_pc,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_target,
  output logic [HIST_W-1:0] o_pred_history,
  input  logic              i_upd_valid,
  input  logic [31:0]       i_upd_pc,
  input  logic [HIST_W-1:0] i_upd_history,
  input  logic              i_upd_taken,
  input  logic [31:0]       i_upd_target
);

  localparam int PHT_N = 1 << HIST_W;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = 30 - BTB_IDX;

  logic [HIST_W-1:0] r_ghr;
  logic [1:0]        r_pht        [PHT_N];
  logic [BTB_N-1:0]  r_btb_valid;
  logic [TAG_W-1:0]  r_btb_tag    [BTB_N];
  logic [31:0]       r_btb_target [BTB_N];

  logic [HIST_W-1:0]  w_pidx;
  logic [BTB_IDX-1:0] w_bidx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;

  logic [HIST_W-1:0]  w_uidx;
  logic [BTB_IDX-1:0] w_upd_bidx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic [1:0]         w_ctr_old;
  logic [1:0]         w_ctr_next;
  logic               w_unused;

  assign w_pidx = i_fetch_pc[HIST_W+1:2] ^ r_ghr;
  assign w_bidx = i_fetch_pc[BTB_IDX+1:2];
  assign w_tag  = i_fetch_pc[31:BTB_IDX+2];
  assign w_hit  = r_btb_valid[w_bidx] && (r_btb_tag[w_bidx] == w_tag);

  assign o_pred_taken   = w_hit && r_pht[w_pidx][1];
  assign o_pred_target  = w_hit ? r_btb_target[w_bidx] : (i_fetch_pc + 32'd4);
  assign o_pred_history = r_ghr;

  // Training indexes with the history carried down the pipe, not the live GHR.
  assign w_uidx     = i_upd_pc[HIST_W+1:2] ^ i_upd_history;
  assign w_upd_bidx = i_upd_pc[BTB_IDX+1:2];
  assign w_upd_tag  = i_upd_pc[31:BTB_IDX+2];
  assign w_ctr_old  = r_pht[w_uidx];

  always_comb begin
    w_ctr_next = w_ctr_old;
    if (i_upd_taken) begin
      if (w_ctr_old != 2'b11) w_ctr_next = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_next = w_ctr_old - 2'd1;
    end
  end

  assign w_unused = ^i_upd_pc[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr       <= '0;
      r_btb_valid <= '0;
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
    end else if (i_upd_valid) begin
      r_pht[w_uidx] <= w_ctr_next;
      r_ghr         <= {r_ghr[HIST_W-2:0], i_upd_taken};
      if (i_upd_taken) r_btb_valid[w_upd_bidx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; the valid bits gate every use.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_upd_valid && i_upd_taken) begin
      r_btb_tag[w_upd_bidx]    <= w_upd_tag;
      r_btb_target[w_upd_bidx] <= i_upd_target;
    end
  end

endmodule
